// File: rtl/pipeline_fetch_unit_pkg.sv
// Shared pipeline definitions: default widths, instruction field layout,
// opcode encodings and the fetch-entry record passed from fetch to decode.
package pipeline_pkg;

   localparam int unsigned DEF_PC_WIDTH    = 8;
   localparam int unsigned DEF_INSTR_WIDTH = 16;

   // Instruction field bit positions: opcode | rs1 | rs2 | rd
   localparam int unsigned OPCODE_MSB = 15;
   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned RS1_MSB    = 11;
   localparam int unsigned RS1_LSB    = 8;
   localparam int unsigned RS2_MSB    = 7;
   localparam int unsigned RS2_LSB    = 4;
   localparam int unsigned RD_MSB     = 3;
   localparam int unsigned RD_LSB     = 0;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_ADD   = 4'h1,
      OP_SUB   = 4'h2,
      OP_LOAD  = 4'h3,
      OP_STORE = 4'h4
   } opcode_e;

   // One buffered instruction tagged with the PC it was fetched from
   typedef struct packed {
      logic [DEF_PC_WIDTH-1:0]    pc;
      logic [DEF_INSTR_WIDTH-1:0] instr;
   } fetch_entry_t;

   function automatic logic [3:0] get_opcode(input logic [DEF_INSTR_WIDTH-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [DEF_INSTR_WIDTH-1:0] make_instr(
      input opcode_e    op,
      input logic [3:0] rs1,
      input logic [3:0] rs2,
      input logic [3:0] rd
   );
      return {op, rs1, rs2, rd};
   endfunction

endpackage

// File: rtl/pipeline_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect control
// and the valid/ready handshake towards decode.
interface pipeline_fetch_unit_if
   import pipeline_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
   parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
);

   logic                   fetch_en;
   logic                   imem_req;
   logic [PC_WIDTH-1:0]    imem_addr;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   redirect_valid;
   logic [PC_WIDTH-1:0]    redirect_pc;
   logic                   if_valid;
   logic [INSTR_WIDTH-1:0] if_instr;
   logic [PC_WIDTH-1:0]    if_pc;
   logic                   id_ready;

   // Fetch unit side
   modport master (
      input  fetch_en, imem_rdata, redirect_valid, redirect_pc, id_ready,
      output imem_req, imem_addr, if_valid, if_instr, if_pc
   );

   // Environment side: memory, branch unit and decode
   modport slave (
      output fetch_en, imem_rdata, redirect_valid, redirect_pc, id_ready,
      input  imem_req, imem_addr, if_valid, if_instr, if_pc
   );

endinterface

// File: rtl/pipeline_fetch_unit_fifo.sv
// Generic synchronous FIFO with push/pop/clear, full/empty flags and an
// occupancy count. Pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter.
module fetch_fifo
   import pipeline_pkg::*;
#(
   parameter int unsigned WIDTH = $bits(fetch_entry_t),
   parameter int unsigned DEPTH = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Status flags and guarded push/pop; a push into a full FIFO is only
   // accepted when the head leaves in the same cycle
   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      count   = wr_ptr - rd_ptr;
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = mem[rd_ptr[AW-1:0]];
   end

   // Pointer update; clear empties the FIFO and wins over push/pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset since empty masks them
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle
// latency instruction memory, buffers returned instructions with their PC
// and hands them to decode over valid/ready. Supports redirect/flush,
// fetch enable and back-pressure.
module pipeline_fetch_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = DEF_PC_WIDTH,
   parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int unsigned DEPTH       = 4
)(
   input logic                   clk,
   input logic                   reset,
   pipeline_fetch_unit_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned EW = PC_WIDTH + INSTR_WIDTH;
   localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(DEPTH);

   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] inflight_pc;
   logic                inflight;

   logic                issue;
   logic                push;
   logic                pop;
   logic                head_valid;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CW-1:0]       occupancy;
   logic [CW:0]         credit_used;
   logic [EW-1:0]       push_entry;
   logic [EW-1:0]       head_entry;

   // Credit check counts buffered plus in-flight entries; a same-cycle pop
   // is deliberately ignored so credit never depends on decode's ready.
   // Reset gates the request and valid outputs so they drop immediately.
   always_comb begin
      credit_used = {1'b0, occupancy} + {{CW{1'b0}}, inflight};
      issue       = !reset && bus.fetch_en && !bus.redirect_valid &&
                    (credit_used < DEPTH_LIMIT);
      push        = inflight && !bus.redirect_valid;
      head_valid  = !reset && !fifo_empty && !bus.redirect_valid;
      pop         = head_valid && bus.id_ready;
      push_entry  = {inflight_pc, bus.imem_rdata};
   end

   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc;
   assign bus.if_valid  = head_valid;
   assign bus.if_pc     = fifo_empty ? '0 : head_entry[EW-1:INSTR_WIDTH];
   assign bus.if_instr  = fifo_empty ? '0 : head_entry[INSTR_WIDTH-1:0];

   // PC and in-flight tracking; redirect reloads the PC and drops any
   // outstanding response so the data returned next cycle is ignored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (bus.redirect_valid) begin
         pc       <= bus.redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc          <= pc + PC_WIDTH'(1);
            inflight_pc <= pc;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (bus.redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occupancy)
   );

   // A response only arrives against a reserved credit, so it can never
   // land in a full buffer
   assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Self-checking bench for pipeline_fetch_unit: a queue-based reference model
// predicts the fetch outputs every cycle, directed sequences pin the model
// with hand-computed literals, and a randomized phase exercises mixes of
// back-pressure, fetch enable, redirects and resets.
module tb_pipeline_fetch_unit;
   import pipeline_pkg::*;

   localparam int unsigned PW    = 8;
   localparam int unsigned IW    = 16;
   localparam int unsigned DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   pipeline_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

   pipeline_fetch_unit #(
      .PC_WIDTH    (PW),
      .INSTR_WIDTH (IW),
      .DEPTH       (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [IW-1:0] mem [256];
   int errors = 0;
   int checks = 0;
   bit cmp_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory: one-cycle read latency, garbage when not requested
   always @(posedge clk) begin
      if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
      else              bus.imem_rdata <= IW'($urandom);
   end

   // Reference model: queue of fetched entries plus the pending fetch address
   fetch_entry_t  q[$];
   logic [PW-1:0] m_pc;
   logic [PW-1:0] m_if_pc;
   bit            m_if;

   function automatic bit m_req();
      return !reset && bus.fetch_en && !bus.redirect_valid && ((q.size() + int'(m_if)) < DEPTH);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         m_pc    = '0;
         m_if    = 0;
         m_if_pc = '0;
      end else begin
         bit iss;
         bit pp;
         iss = m_req();
         pp  = (q.size() > 0) && !bus.redirect_valid && bus.id_ready;
         if (bus.redirect_valid) begin
            q.delete();
            m_pc = bus.redirect_pc;
            m_if = 0;
         end else begin
            if (pp) void'(q.pop_front());
            if (m_if) begin
               check("no_overflow", q.size() < DEPTH, 1);
               q.push_back('{pc: m_if_pc, instr: mem[m_if_pc]});
            end
            if (iss) begin
               m_if_pc = m_pc;
               m_pc    = m_pc + 8'd1;
            end
            m_if = iss;
         end
      end
   end

   // Compare DUT against the model mid-cycle
   always @(negedge clk) begin
      if (cmp_en) begin
         bit ev;
         ev = !reset && (q.size() > 0) && !bus.redirect_valid;
         check("imem_req", bus.imem_req, m_req());
         check("imem_addr", bus.imem_addr, m_pc);
         check("if_valid", bus.if_valid, ev);
         if (ev) begin
            check("if_instr", bus.if_instr, q[0].instr);
            check("if_pc", bus.if_pc, q[0].pc);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns with the bench at the start of cycle 0 after release
   task automatic do_reset();
      reset = 1'b1;
      bus.fetch_en = 1'b1;
      bus.id_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic next_accept(input string name, output logic [PW-1:0] pc);
      bit ok;
      ok = 0;
      pc = '0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (bus.if_valid && bus.id_ready) begin
            ok = 1;
            pc = bus.if_pc;
         end
         tick();
      end
      check({name, "_accept"}, ok, 1);
   endtask

   logic [IW-1:0] t1_instr [5] = '{16'h1123, 16'h2124, 16'h3105, 16'h4120, 16'h0000};
   logic [PW-1:0] t4_exp   [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

   initial begin
      logic [PW-1:0] p;
      bit prev;

      for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
      for (int i = 0; i < 5; i++) mem[i] = t1_instr[i];
      mem[16] = 16'h2345;
      bus.fetch_en = 1'b1;
      bus.id_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;

      // Reset state
      #1 reset = 1'b1;
      #1;
      check("rst_valid", bus.if_valid, 0);
      check("rst_instr", bus.if_instr, 0);
      check("rst_pc", bus.if_pc, 0);
      check("rst_req", bus.imem_req, 0);
      cmp_en = 1;

      // 1: streaming, first instruction two cycles after the first request
      do_reset();
      @(negedge clk);
      check("t1_c0_req", bus.imem_req, 1);
      check("t1_c0_addr", bus.imem_addr, 0);
      check("t1_c0_valid", bus.if_valid, 0);
      tick();
      @(negedge clk);
      check("t1_c1_valid", bus.if_valid, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t1_valid", bus.if_valid, 1);
         check("t1_instr", bus.if_instr, t1_instr[i]);
         check("t1_pc", bus.if_pc, i);
         tick();
      end

      // 2: back-pressure fills the buffer and stops requests
      do_reset();
      bus.id_ready = 1'b0;
      tick(9);
      @(negedge clk);
      check("t2_hold_valid", bus.if_valid, 1);
      check("t2_hold_instr", bus.if_instr, 16'h1123);
      check("t2_hold_pc", bus.if_pc, 0);
      check("t2_req_stop", bus.imem_req, 0);
      tick();
      bus.id_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         next_accept("t2", p);
         check("t2_order", p, i);
      end

      // 3: redirect while a response is in flight
      prev = 0;
      for (int c = 0; c < 20 && !prev; c++) begin
         @(negedge clk);
         prev = bus.imem_req;
         tick();
      end
      check("t3_prev_req", prev, 1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 8'h10;
      @(negedge clk);
      check("t3_r_req", bus.imem_req, 0);
      check("t3_r_valid", bus.if_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      check("t3_r1_req", bus.imem_req, 1);
      check("t3_r1_addr", bus.imem_addr, 8'h10);
      check("t3_r1_valid", bus.if_valid, 0);
      tick();
      @(negedge clk);
      check("t3_r2_valid", bus.if_valid, 0);
      tick();
      @(negedge clk);
      check("t3_r3_valid", bus.if_valid, 1);
      check("t3_r3_instr", bus.if_instr, 16'h2345);
      check("t3_r3_pc", bus.if_pc, 8'h10);
      tick();

      // 4: PC wraps modulo 256
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 8'hFE;
      tick();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         next_accept("t4", p);
         check("t4_wrap_pc", p, t4_exp[i]);
      end

      // 5: asynchronous reset with a full buffer
      bus.id_ready = 1'b0;
      tick(10);
      check("t5_full_valid", bus.if_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("t5_async_valid", bus.if_valid, 0);
      check("t5_async_instr", bus.if_instr, 0);
      check("t5_async_pc", bus.if_pc, 0);
      check("t5_async_req", bus.imem_req, 0);
      tick();
      reset = 1'b0;
      bus.id_ready = 1'b1;
      next_accept("t5", p);
      check("t5_restart_pc", p, 0);

      // 6: fetch enable dropped for three cycles mid-stream
      begin : t6
         logic [PW-1:0] prev6;
         bit have;
         int n6;
         have = 0;
         n6 = 0;
         prev6 = '0;
         for (int c = 0; c < 30; c++) begin
            bus.fetch_en = !(c >= 8 && c < 11);
            @(negedge clk);
            if (c >= 8 && c < 11) check("t6_req_off", bus.imem_req, 0);
            if (bus.if_valid && bus.id_ready) begin
               if (have) check("t6_seq", bus.if_pc, 8'(prev6 + 8'd1));
               prev6 = bus.if_pc;
               have = 1;
               n6++;
            end
            tick();
         end
         check("t6_delivered", n6 >= 20, 1);
         bus.fetch_en = 1'b1;
      end

      // Randomized mix checked by the model
      for (int c = 0; c < 3000; c++) begin
         bus.fetch_en = ($urandom_range(0, 9) != 0);
         bus.id_ready = ($urandom_range(0, 2) != 0);
         bus.redirect_valid = ($urandom_range(0, 29) == 0);
         bus.redirect_pc = PW'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            #2 reset = 1'b1;
            tick();
            reset = 1'b0;
         end else begin
            tick();
         end
      end

      cmp_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
